// File: rtl/fault_dict_pkg.sv
// fault_dict_pkg: shared state encoding, default widths and address-width helpers
package fault_dict_pkg;
    typedef enum logic [2:0] {IDLE, INJECT, FETCH, LATCH, APPLY, COMPARE, EMIT, DONE} state_t;
    localparam int DEF_IN_W      = 60;
    localparam int DEF_OUT_W     = 26;
    localparam int DEF_TEST_CNT  = 66;
    localparam int DEF_FAULT_CNT = 980;
    localparam int DEF_SETTLE    = 2;
    function automatic int pa_w(input int test_cnt);
        return test_cnt > 1 ? $clog2(test_cnt) : 1;
    endfunction
    function automatic int fi_w(input int fault_cnt);
        return fault_cnt > 1 ? $clog2(fault_cnt) : 1;
    endfunction
endpackage

// File: rtl/fault_dict_if.sv
// fault_dict_if: valid/ready dictionary record port (fault index + syndrome)
interface fault_dict_if import fault_dict_pkg::*; #(
    parameter int FI_W     = fi_w(DEF_FAULT_CNT),
    parameter int TEST_CNT = DEF_TEST_CNT
) ();
    logic                dct_valid;
    logic                dct_ready;
    logic [FI_W-1:0]     dct_fault;
    logic [TEST_CNT-1:0] dct_syndrome;
    modport master (output dct_valid, dct_fault, dct_syndrome, input dct_ready);
    modport slave (input dct_valid, dct_fault, dct_syndrome, output dct_ready);
endinterface

// File: rtl/fault_dict_syndrome.sv
// fault_dict_syndrome: per-pattern detection bits from a full-width good/faulty compare
module fault_dict_syndrome #(
    parameter int OUT_W    = 26,
    parameter int TEST_CNT = 66,
    parameter int PA_W     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                set,
    input  logic [PA_W-1:0]     idx,
    input  logic [OUT_W-1:0]    good,
    input  logic [OUT_W-1:0]    faulty,
    output logic [TEST_CNT-1:0] syndrome,
    output logic                nonzero
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            syndrome <= '0;
        else if (set)
            syndrome[idx] <= good != faulty;
    end
    assign nonzero = |syndrome;
endmodule

// File: rtl/fault_dict_sequencer.sv
// fault_dict_sequencer: injects each fault, sweeps every pattern through the good/faulty
// CUT pair and streams one syndrome record per fault while counting detected faults.
module fault_dict_sequencer import fault_dict_pkg::*; #(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int TEST_CNT  = DEF_TEST_CNT,
    parameter int FAULT_CNT = DEF_FAULT_CNT,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int PA_W      = pa_w(TEST_CNT),
    parameter int FI_W      = fi_w(FAULT_CNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [PA_W-1:0]  pat_addr,
    input  logic [IN_W-1:0]  pat_data,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] good_out,
    input  logic [OUT_W-1:0] fault_out,
    output logic [FI_W-1:0]  fault_idx,
    output logic             inj_en,
    fault_dict_if.master     dct,
    output logic [FI_W:0]    det_count
);
    localparam int SW = $clog2(SETTLE + 1);
    state_t          state, nxt;
    logic [PA_W-1:0] j;
    logic [SW-1:0]   cnt;
    logic            last_pat, last_fault, accept, hs, nonzero;

    assign last_pat      = j == PA_W'(TEST_CNT - 1);
    assign last_fault    = fault_idx == FI_W'(FAULT_CNT - 1);
    assign accept        = (state == IDLE || state == DONE) && start;
    assign hs            = state == EMIT && dct.dct_ready;
    assign busy          = state != IDLE && state != DONE;
    assign done          = state == DONE;
    assign pat_addr      = j;
    assign dct.dct_valid = state == EMIT;
    assign dct.dct_fault = fault_idx;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // LATCH skips APPLY when a single settle cycle is enough
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? INJECT : state;
            INJECT:     nxt = FETCH;
            FETCH:      nxt = LATCH;
            LATCH:      nxt = SETTLE == 1 ? COMPARE : APPLY;
            APPLY:      nxt = int'(cnt) <= 2 ? COMPARE : APPLY;
            COMPARE:    nxt = last_pat ? EMIT : FETCH;
            EMIT:       nxt = !dct.dct_ready ? EMIT : last_fault ? DONE : INJECT;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j         <= '0;
            cnt       <= '0;
            cut_in    <= '0;
            fault_idx <= '0;
            det_count <= '0;
            inj_en    <= 1'b0;
        end else begin
            if (accept) begin
                fault_idx <= '0;
                det_count <= '0;
            end
            if (state == INJECT) begin
                inj_en <= 1'b1;
                j      <= '0;
            end
            if (state == LATCH) begin
                cut_in <= pat_data;
                cnt    <= SW'(SETTLE);
            end
            if (state == APPLY)
                cnt <= cnt - 1'b1;
            if (state == COMPARE && !last_pat)
                j <= j + 1'b1;
            if (hs) begin
                inj_en <= 1'b0;
                if (nonzero && det_count != (FI_W+1)'(FAULT_CNT))
                    det_count <= det_count + 1'b1;
                if (!last_fault)
                    fault_idx <= fault_idx + 1'b1;
            end
        end
    end

    fault_dict_syndrome #(.OUT_W(OUT_W), .TEST_CNT(TEST_CNT), .PA_W(PA_W)) u_syn (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == INJECT),
        .set      (state == COMPARE),
        .idx      (j),
        .good     (good_out),
        .faulty   (fault_out),
        .syndrome (dct.dct_syndrome),
        .nonzero  (nonzero)
    );
endmodule

// File: tb/tb_fault_dict_sequencer.sv
// tb_fault_dict_sequencer: scoreboard bench; CUT pair and ROM modelled here, records
// predicted from a per-fault/per-pattern detection table.
module tb_fault_dict_sequencer;
    import fault_dict_pkg::*;
    localparam int IN_W = 60, OUT_W = 26, TC = 4, FC = 3, ST = 2;
    localparam int PA_W = pa_w(TC), FI_W = fi_w(FC);
    typedef struct packed {
        logic [FI_W-1:0] f;
        logic [TC-1:0]   s;
    } rec_t;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic             busy, done, inj_en;
    logic [PA_W-1:0]  pat_addr;
    logic [IN_W-1:0]  pat_data, cut_in;
    logic [OUT_W-1:0] good_out, fault_out, m;
    logic [FI_W-1:0]  fault_idx;
    logic [FI_W:0]    det_count;
    logic [IN_W-1:0]  rom [TC];
    logic [OUT_W-1:0] fmask [FC][TC];
    logic [IN_W-1:0]  prev_in = '0;
    logic             settled, prev_hs = 1'b0;
    int               age = 0, n_cmp = 0, n_bad = 0, exp_det = 0, rdy_mode = 0;
    rec_t             q[$];

    fault_dict_if #(.FI_W(FI_W), .TEST_CNT(TC)) dct ();

    fault_dict_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .TEST_CNT(TC), .FAULT_CNT(FC), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pat_addr(pat_addr), .pat_data(pat_data), .cut_in(cut_in),
        .good_out(good_out), .fault_out(fault_out), .fault_idx(fault_idx),
        .inj_en(inj_en), .dct(dct), .det_count(det_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pat_data <= rom[pat_addr];

    // faulty CUT shows the inverse detection until ST cycles after cut_in changes
    always @(posedge clk) begin
        prev_in <= cut_in;
        age     <= (cut_in != prev_in) ? 0 : age + 1;
    end
    assign good_out = cut_in[OUT_W-1:0] ^ cut_in[IN_W-1:IN_W-OUT_W];
    always_comb begin
        settled   = (cut_in != prev_in) ? (ST == 1) : (age + 1 >= ST - 1);
        m         = inj_en ? fmask[fault_idx][cut_in[PA_W-1:0]] : '0;
        fault_out = good_out ^ (settled ? m : (m == '0 ? OUT_W'(1) : '0));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (prev_hs) check("inj_gap", inj_en, 0);
        if (rst_n && dct.dct_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got fault %0d, expected no record", dct.dct_fault);
            end else begin
                check("rec_fault", dct.dct_fault, q[0].f);
                check("rec_syndrome", dct.dct_syndrome, q[0].s);
                check("inj_during_emit", inj_en, 1);
                if (dct.dct_ready) void'(q.pop_front());
            end
        end
        prev_hs <= rst_n && dct.dct_valid && dct.dct_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
        dct.dct_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic randomize_faults();
        for (int f = 0; f < FC; f++)
            for (int k = 0; k < TC; k++)
                fmask[f][k] = ($urandom_range(0, 2) == 0) ?
                    (OUT_W'($urandom) | OUT_W'(1) << $urandom_range(0, OUT_W - 1)) : '0;
    endtask

    task automatic push_run();
        rec_t r;
        exp_det = 0;
        for (int f = 0; f < FC; f++) begin
            r.f = FI_W'(f);
            r.s = '0;
            for (int k = 0; k < TC; k++) r.s[k] = fmask[f][k] != '0;
            if (r.s != '0) exp_det++;
            q.push_back(r);
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            step();
            n++;
        end
        check("done_reached", done, 1);
        check("busy_after_done", busy, 0);
        check("det_count", det_count, exp_det);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_inj_en"}, inj_en, 0);
        check({tag, "_valid"}, dct.dct_valid, 0);
        check({tag, "_pat_addr"}, pat_addr, 0);
        check({tag, "_cut_in"}, cut_in, 0);
        check({tag, "_fault_idx"}, fault_idx, 0);
        check({tag, "_dct_fault"}, dct.dct_fault, 0);
        check({tag, "_syndrome"}, dct.dct_syndrome, 0);
        check({tag, "_det_count"}, det_count, 0);
        check({tag, "_state"}, dut.state, IDLE);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < TC; k++)
            rom[k] = (IN_W'({$urandom, $urandom}) << PA_W) | IN_W'(k);
        for (int f = 0; f < FC; f++)
            for (int k = 0; k < TC; k++) fmask[f][k] = '0;
        dct.dct_ready = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // abort a run from APPLY
        randomize_faults();
        pulse_start();
        repeat (3) step();
        check("mid_state_apply", dut.state, APPLY);
        check("mid_inj_en", inj_en, 1);
        rst_n = 1'b0;
        step();
        check_all_zero("midrst");
        rst_n = 1'b1;
        repeat (30) step();
        check("midrst_no_valid", dct.dct_valid, 0);

        // directed: fault 1 flips bit 0 on patterns 0 and 2
        for (int f = 0; f < FC; f++)
            for (int k = 0; k < TC; k++) fmask[f][k] = '0;
        fmask[1][0] = OUT_W'(1);
        fmask[1][2] = OUT_W'(1);
        push_run();
        check("model_rec1", q[1].s, 4'b0101);
        start = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
            start = 1'b0;
        end while (!dct.dct_valid && cyc < 100);
        check("first_valid_latency", cyc, 18);
        repeat (6) step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("busy_start_fault_idx", fault_idx, 1);
        check("busy_start_busy", busy, 1);
        wait_done(500);

        // rerun from DONE with identical table
        push_run();
        pulse_start();
        check("rerun_det_restart", det_count, 0);
        check("rerun_done_cleared", done, 0);
        check("rerun_busy", busy, 1);
        wait_done(500);

        // backpressure on fault 0
        randomize_faults();
        push_run();
        rdy_mode = 1;
        pulse_start();
        cyc = 0;
        while (!dct.dct_valid && cyc < 100) begin
            step();
            cyc++;
        end
        check("bp_valid_reached", dct.dct_valid, 1);
        repeat (10) begin
            step();
            check("bp_valid_held", dct.dct_valid, 1);
            check("bp_fault_idx_held", fault_idx, 0);
        end
        rdy_mode = 0;
        dct.dct_ready = 1'b1;
        step();
        check("bp_fault_idx_adv", fault_idx, 1);
        check("bp_valid_drop", dct.dct_valid, 0);
        rdy_mode = 2;
        wait_done(2000);

        // random tables with random backpressure
        repeat (8) begin
            randomize_faults();
            push_run();
            pulse_start();
            wait_done(3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
